// File: rtl/rv32_decode_stage.sv
// Registered RV32I decode stage: instruction + PC in, ALU control, operand selects and immediate out.
// Latency: exactly one clock from instr_in/pc_in to the decoded outputs; no internal buffering.
// Backpressure: stall_in freezes every output register, and upstream must honour the same stall; flush_in wins over stall_in.
//
// Ports:
//   clk, reset_n             clock and asynchronous active-low reset
//   valid_in, instr_in, pc_in   fetched instruction and its address
//   stall_in, flush_in       execute hold request and pipeline kill
//   valid_out, pc_out        live flag and registered PC
//   rs1_out/rs2_out/rd_out   raw register index fields
//   alu_op_out, alu_sub_sra_out, alu_src1_out, alu_src2_out, imm_value_out   ALU control
//   rd_write_out, branch_out, jump_out, mem_read_out, mem_write_out, illegal_out   class flags
module rv32_decode_stage #(
  parameter logic [31:0] RESET_PC_TAG = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic        stall_in,
  input  logic        flush_in,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [4:0]  rs1_out,
  output logic [4:0]  rs2_out,
  output logic [4:0]  rd_out,
  output logic [2:0]  alu_op_out,
  output logic        alu_sub_sra_out,
  output logic [1:0]  alu_src1_out,
  output logic [1:0]  alu_src2_out,
  output logic [31:0] imm_value_out,
  output logic        rd_write_out,
  output logic        branch_out,
  output logic        jump_out,
  output logic        mem_read_out,
  output logic        mem_write_out,
  output logic        illegal_out
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD_SUB = 3'b000;
  localparam logic [2:0] ALU_XOR     = 3'b001;
  localparam logic [2:0] ALU_OR      = 3'b010;
  localparam logic [2:0] ALU_AND     = 3'b011;
  localparam logic [2:0] ALU_SLL     = 3'b100;
  localparam logic [2:0] ALU_SRL_SRA = 3'b101;
  localparam logic [2:0] ALU_SLT     = 3'b110;
  localparam logic [2:0] ALU_SLTU    = 3'b111;

  localparam logic [1:0] SRC1_REG  = 2'b00;
  localparam logic [1:0] SRC1_PC   = 2'b01;
  localparam logic [1:0] SRC1_ZERO = 2'b10;
  localparam logic [1:0] SRC2_REG  = 2'b00;
  localparam logic [1:0] SRC2_IMM  = 2'b01;
  localparam logic [1:0] SRC2_FOUR = 2'b10;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_idx;

  assign opcode = instr_in[6:0];
  assign funct3 = instr_in[14:12];
  assign funct7 = instr_in[31:25];
  assign rd_idx = instr_in[11:7];

  // Immediate formats, all sign-extended from instr[31] except U.
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign imm_i = {{20{instr_in[31]}}, instr_in[31:20]};
  assign imm_s = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
  assign imm_b = {{19{instr_in[31]}}, instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8], 1'b0};
  assign imm_u = {instr_in[31:12], 12'b0};
  assign imm_j = {{11{instr_in[31]}}, instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21], 1'b0};

  function automatic logic [2:0] alu_from_funct3(input logic [2:0] f3);
    logic [2:0] op;
    case (f3)
      3'b000:  op = ALU_ADD_SUB;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL_SRA;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Next-state decode of the incoming instruction.
  logic [2:0]  d_alu_op;
  logic        d_sub_sra;
  logic [1:0]  d_src1, d_src2;
  logic [31:0] d_imm;
  logic        d_writes_rd, d_branch, d_jump, d_mem_read, d_mem_write, d_illegal;
  logic        n_rd_write, n_branch, n_jump, n_mem_read, n_mem_write, n_illegal;

  always_comb begin
    d_alu_op    = ALU_ADD_SUB;
    d_sub_sra   = 1'b0;
    d_src1      = SRC1_REG;
    d_src2      = SRC2_REG;
    d_imm       = 32'h0;
    d_writes_rd = 1'b0;
    d_branch    = 1'b0;
    d_jump      = 1'b0;
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    d_illegal   = 1'b0;

    case (opcode)
      OPC_OP: begin
        d_alu_op    = alu_from_funct3(funct3);
        d_sub_sra   = (funct3 == 3'b000 || funct3 == 3'b101) && instr_in[30];
        d_writes_rd = 1'b1;
        if (funct7 == F7_ALT)
          d_illegal = !(funct3 == 3'b000 || funct3 == 3'b101);
        else if (funct7 != F7_ZERO)
          d_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        d_alu_op    = alu_from_funct3(funct3);
        // ADDI has no subtract form; bit 30 only selects SRAI.
        d_sub_sra   = (funct3 == 3'b101) && instr_in[30];
        d_src2      = SRC2_IMM;
        d_imm       = imm_i;
        d_writes_rd = 1'b1;
        if (funct3 == 3'b001)
          d_illegal = (funct7 != F7_ZERO);
        else if (funct3 == 3'b101)
          d_illegal = !(funct7 == F7_ZERO || funct7 == F7_ALT);
      end
      OPC_LUI: begin
        d_src1      = SRC1_ZERO;
        d_src2      = SRC2_IMM;
        d_imm       = imm_u;
        d_writes_rd = 1'b1;
      end
      OPC_AUIPC: begin
        d_src1      = SRC1_PC;
        d_src2      = SRC2_IMM;
        d_imm       = imm_u;
        d_writes_rd = 1'b1;
      end
      OPC_JAL: begin
        // ALU produces the link address PC+4.
        d_src1      = SRC1_PC;
        d_src2      = SRC2_FOUR;
        d_imm       = imm_j;
        d_writes_rd = 1'b1;
        d_jump      = 1'b1;
      end
      OPC_JALR: begin
        d_src1      = SRC1_PC;
        d_src2      = SRC2_FOUR;
        d_imm       = imm_i;
        d_writes_rd = 1'b1;
        d_jump      = 1'b1;
        d_illegal   = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        d_src1    = SRC1_PC;
        d_src2    = SRC2_IMM;
        d_imm     = imm_b;
        d_branch  = 1'b1;
        d_illegal = (funct3 == 3'b010 || funct3 == 3'b011);
      end
      OPC_LOAD: begin
        d_src2      = SRC2_IMM;
        d_imm       = imm_i;
        d_writes_rd = 1'b1;
        d_mem_read  = 1'b1;
        d_illegal   = (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
      end
      OPC_STORE: begin
        d_src2      = SRC2_IMM;
        d_imm       = imm_s;
        d_mem_write = 1'b1;
        d_illegal   = (funct3 >= 3'b011);
      end
      default: d_illegal = 1'b1;
    endcase

    // Compressed / non-32-bit encodings are not supported.
    if (instr_in[1:0] != 2'b11)
      d_illegal = 1'b1;
  end

  // Side-effect flags are suppressed for bubbles and for illegal encodings so
  // a trap never also writes a register or touches memory.
  always_comb begin
    n_illegal   = valid_in && d_illegal;
    n_rd_write  = valid_in && !d_illegal && d_writes_rd && (rd_idx != 5'd0);
    n_branch    = valid_in && !d_illegal && d_branch;
    n_jump      = valid_in && !d_illegal && d_jump;
    n_mem_read  = valid_in && !d_illegal && d_mem_read;
    n_mem_write = valid_in && !d_illegal && d_mem_write;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out       <= 1'b0;
      pc_out          <= RESET_PC_TAG;
      rs1_out         <= 5'd0;
      rs2_out         <= 5'd0;
      rd_out          <= 5'd0;
      alu_op_out      <= ALU_ADD_SUB;
      alu_sub_sra_out <= 1'b0;
      alu_src1_out    <= SRC1_REG;
      alu_src2_out    <= SRC2_REG;
      imm_value_out   <= 32'h0;
      rd_write_out    <= 1'b0;
      branch_out      <= 1'b0;
      jump_out        <= 1'b0;
      mem_read_out    <= 1'b0;
      mem_write_out   <= 1'b0;
      illegal_out     <= 1'b0;
    end else if (flush_in) begin
      // Only the liveness and side-effect flags matter for a killed slot.
      valid_out     <= 1'b0;
      rd_write_out  <= 1'b0;
      branch_out    <= 1'b0;
      jump_out      <= 1'b0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
      illegal_out   <= 1'b0;
    end else if (!stall_in) begin
      valid_out       <= valid_in;
      pc_out          <= pc_in;
      rs1_out         <= instr_in[19:15];
      rs2_out         <= instr_in[24:20];
      rd_out          <= rd_idx;
      alu_op_out      <= d_alu_op;
      alu_sub_sra_out <= d_sub_sra;
      alu_src1_out    <= d_src1;
      alu_src2_out    <= d_src2;
      imm_value_out   <= d_imm;
      rd_write_out    <= n_rd_write;
      branch_out      <= n_branch;
      jump_out        <= n_jump;
      mem_read_out    <= n_mem_read;
      mem_write_out   <= n_mem_write;
      illegal_out     <= n_illegal;
    end
  end

endmodule

// File: tb/tb_rv32_decode_stage.sv
module tb_rv32_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_in;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        stall_in;
  logic        flush_in;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [4:0]  rs1_out, rs2_out, rd_out;
  logic [2:0]  alu_op_out;
  logic        alu_sub_sra_out;
  logic [1:0]  alu_src1_out, alu_src2_out;
  logic [31:0] imm_value_out;
  logic        rd_write_out, branch_out, jump_out, mem_read_out, mem_write_out, illegal_out;

  always #5 clk = ~clk;

  rv32_decode_stage #(.RESET_PC_TAG(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .instr_in(instr_in), .pc_in(pc_in),
    .stall_in(stall_in), .flush_in(flush_in), .valid_out(valid_out), .pc_out(pc_out),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rd_out(rd_out), .alu_op_out(alu_op_out),
    .alu_sub_sra_out(alu_sub_sra_out), .alu_src1_out(alu_src1_out), .alu_src2_out(alu_src2_out),
    .imm_value_out(imm_value_out), .rd_write_out(rd_write_out), .branch_out(branch_out),
    .jump_out(jump_out), .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
    .illegal_out(illegal_out)
  );

  // full=0 marks a flushed slot: only liveness and side-effect flags are checked.
  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  op;
    logic        sub;
    logic [1:0]  s1, s2;
    logic [31:0] imm;
    logic        rdw, br, jmp, mr, mw, ill;
    logic        full;
  } exp_t;

  exp_t  exp_q[$];
  int    tag_q[$];
  string name_q[$];
  int    cyc = 0;
  int    n_chk = 0;
  int    n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
                              input logic [2:0] op, input logic sub, input logic [1:0] s1, s2,
                              input logic [31:0] imm, input logic rdw, br, jmp, mr, mw, ill);
    exp_t e;
    e.vld = v; e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.op = op; e.sub = sub;
    e.s1 = s1; e.s2 = s2; e.imm = imm; e.rdw = rdw; e.br = br; e.jmp = jmp; e.mr = mr;
    e.mw = mw; e.ill = ill; e.full = 1'b1;
    return e;
  endfunction

  // Monitor: pops an expectation once the edge that loads it has passed.
  always @(negedge clk) begin : mon
    exp_t  a, e;
    string nm;
    bit    ok;
    if (exp_q.size() > 0 && tag_q[0] <= cyc) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      void'(tag_q.pop_front());
      a.vld = valid_out; a.pc = pc_out; a.rs1 = rs1_out; a.rs2 = rs2_out; a.rd = rd_out;
      a.op = alu_op_out; a.sub = alu_sub_sra_out; a.s1 = alu_src1_out; a.s2 = alu_src2_out;
      a.imm = imm_value_out; a.rdw = rd_write_out; a.br = branch_out; a.jmp = jump_out;
      a.mr = mem_read_out; a.mw = mem_write_out; a.ill = illegal_out; a.full = 1'b1;
      if (e.full)
        ok = (a === e);
      else
        ok = ({a.vld, a.rdw, a.br, a.jmp, a.mr, a.mw, a.ill} === {e.vld, e.rdw, e.br, e.jmp, e.mr, e.mw, e.ill});
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, expv);
  endtask

  // Drive one cycle of inputs just after a rising edge; the result appears after the next edge.
  task automatic step(input string nm, input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic st, input logic fl, input exp_t e);
    valid_in = v; instr_in = ins; pc_in = pc; stall_in = st; flush_in = fl;
    exp_q.push_back(e);
    tag_q.push_back(cyc + 1);
    name_q.push_back(nm);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clk); budget++;
    end
    @(negedge clk); #1;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
  endtask

  exp_t lui_e, flush_e;

  initial begin
    reset_n = 1'b1; valid_in = 1'b0; instr_in = 32'h0; pc_in = 32'h0;
    stall_in = 1'b0; flush_in = 1'b0;
    flush_e = '0;

    // Asynchronous reset between edges.
    #3 reset_n = 1'b0;
    #1;
    chk("reset_async_vld_pc", {31'd0, valid_out, pc_out}, 64'd0);
    chk("reset_async_src", {60'd0, alu_src1_out, alu_src2_out}, 64'd0);
    chk("reset_async_flags", {36'd0, alu_op_out, alu_sub_sra_out, rd_write_out, branch_out, jump_out,
                              mem_read_out, mem_write_out, illegal_out, 20'd0}, 64'd0);
    valid_in = 1'b1; instr_in = 32'h40B5_0533; pc_in = 32'h10;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_held", {31'd0, valid_out, pc_out}, 64'd0);
    chk("reset_held_imm_rdw", {31'd0, rd_write_out, imm_value_out}, 64'd0);
    reset_n = 1'b1;
    chk("reset_release_no_edge", {63'd0, valid_out}, 64'd0);

    step("sub", 1, 32'h40B5_0533, 32'h10, 0, 0,
         mk(1, 32'h10, 5'd10, 5'd11, 5'd10, 3'b000, 1, 2'b00, 2'b00, 32'h0, 1, 0, 0, 0, 0, 0));
    step("addi_m1", 1, 32'hFFF0_0093, 32'h14, 0, 0,
         mk(1, 32'h14, 5'd0, 5'd31, 5'd1, 3'b000, 0, 2'b00, 2'b01, 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0));
    step("srai", 1, 32'h4020_D093, 32'h18, 0, 0,
         mk(1, 32'h18, 5'd1, 5'd2, 5'd1, 3'b101, 1, 2'b00, 2'b01, 32'h0000_0402, 1, 0, 0, 0, 0, 0));
    step("jal_x0", 1, 32'h0080_006F, 32'h100, 0, 0,
         mk(1, 32'h100, 5'd0, 5'd8, 5'd0, 3'b000, 0, 2'b01, 2'b10, 32'h8, 0, 0, 1, 0, 0, 0));
    lui_e = mk(1, 32'h200, 5'd8, 5'd3, 5'd5, 3'b000, 0, 2'b10, 2'b01, 32'h1234_5000, 1, 0, 0, 0, 0, 0);
    step("lui", 1, 32'h1234_52B7, 32'h200, 0, 0, lui_e);
    step("stall1", 1, 32'h0000_007F, 32'h204, 1, 0, lui_e);
    step("stall2", 0, 32'hFFF0_0093, 32'h208, 1, 0, lui_e);
    step("stall3", 1, 32'h40B5_0533, 32'h20C, 1, 0, lui_e);
    step("flush_over_stall", 1, 32'h0020_A423, 32'h210, 1, 1, flush_e);
    step("bad_opcode", 1, 32'h0000_007F, 32'h300, 0, 0,
         mk(1, 32'h300, 5'd0, 5'd0, 5'd0, 3'b000, 0, 2'b00, 2'b00, 32'h0, 0, 0, 0, 0, 0, 1));
    step("mul_funct7", 1, 32'h02B5_0533, 32'h304, 0, 0,
         mk(1, 32'h304, 5'd10, 5'd11, 5'd10, 3'b000, 0, 2'b00, 2'b00, 32'h0, 0, 0, 0, 0, 0, 1));
    step("sw", 1, 32'h0020_A423, 32'h308, 0, 0,
         mk(1, 32'h308, 5'd1, 5'd2, 5'd8, 3'b000, 0, 2'b00, 2'b01, 32'h8, 0, 0, 0, 0, 1, 0));
    step("beq_m4", 1, 32'hFE20_8EE3, 32'h30C, 0, 0,
         mk(1, 32'h30C, 5'd1, 5'd2, 5'd29, 3'b000, 0, 2'b01, 2'b01, 32'hFFFF_FFFC, 0, 1, 0, 0, 0, 0));
    step("branch_f3_010", 1, 32'hFE20_AEE3, 32'h310, 0, 0,
         mk(1, 32'h310, 5'd1, 5'd2, 5'd29, 3'b000, 0, 2'b01, 2'b01, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 1));
    step("lui_bubble", 0, 32'h1234_52B7, 32'h314, 0, 0,
         mk(0, 32'h314, 5'd8, 5'd3, 5'd5, 3'b000, 0, 2'b10, 2'b01, 32'h1234_5000, 0, 0, 0, 0, 0, 0));
    step("lw", 1, 32'h0041_2183, 32'h318, 0, 0,
         mk(1, 32'h318, 5'd2, 5'd4, 5'd3, 3'b000, 0, 2'b00, 2'b01, 32'h4, 1, 0, 0, 1, 0, 0));
    step("bad_opcode_bubble", 0, 32'h0000_007F, 32'h31C, 0, 0,
         mk(0, 32'h31C, 5'd0, 5'd0, 5'd0, 3'b000, 0, 2'b00, 2'b00, 32'h0, 0, 0, 0, 0, 0, 0));
    lui_e.pc = 32'h400;
    step("lui2", 1, 32'h1234_52B7, 32'h400, 0, 0, lui_e);
    step("lui2_stall", 1, 32'h0000_007F, 32'h404, 1, 0, lui_e);
    drain();

    // Reset while stalled drops the held instruction immediately.
    #2 reset_n = 1'b0;
    #1;
    chk("reset_mid_stall_vld_pc", {31'd0, valid_out, pc_out}, 64'd0);
    chk("reset_mid_stall_imm_rdw", {31'd0, rd_write_out, imm_value_out}, 64'd0);
    chk("reset_mid_stall_src", {60'd0, alu_src1_out, alu_src2_out}, 64'd0);
    stall_in = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rv32_decode_stage.md
Name: rv32_decode_stage

Overview:
- Registered RV32I decode stage: takes a fetched instruction and PC, produces the ALU control and operand-select fields plus the immediate, one cycle later.
- Sits between fetch and execute as the producer side of the ALU control interface.
- Supports downstream stall and pipeline flush; flags illegal encodings.

Parameters:
- RESET_PC_TAG, 32'h0000_0000, value driven on pc_out while reset is asserted.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- valid_in  input  1  instr_in/pc_in hold a real instruction.
- instr_in  input  32  raw instruction word.
- pc_in  input  32  address of instr_in.
- stall_in  input  1  execute cannot accept; hold all outputs.
- flush_in  input  1  kill the instruction in this stage.
- valid_out  output  1  outputs describe a live instruction.
- pc_out  output  32  registered pc_in.
- rs1_out, rs2_out, rd_out  output  5 each  register indices, instr[19:15], [24:20], [11:7].
- alu_op_out  output  3  ADD_SUB=000, XOR=001, OR=010, AND=011, SLL=100, SRL_SRA=101, SLT=110, SLTU=111.
- alu_sub_sra_out  output  1  subtract, or arithmetic right shift.
- alu_src1_out  output  2  REG=00, PC=01, ZERO=10.
- alu_src2_out  output  2  REG=00, IMM=01, FOUR=10.
- imm_value_out  output  32  sign-extended immediate.
- rd_write_out  output  1  result is written to rd.
- branch_out, jump_out, mem_read_out, mem_write_out  output  1 each  instruction class flags.
- illegal_out  output  1  unsupported or malformed encoding.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - pc_out=RESET_PC_TAG.
  - All other outputs 0, i.e. fields decode as ADD, REG, REG.
- Register update priority on each clk edge:
  1. flush_in=1: valid_out<=0, all class flags, rd_write_out and illegal_out <=0. Other fields are don't-care. Flush overrides stall.
  2. stall_in=1: every output holds its value.
  3. Otherwise: every output loads the decode of the inputs; valid_out<=valid_in.
- valid_in=0 when loading: all class flags, rd_write_out and illegal_out load 0.
- Latency: exactly 1 cycle from input to output. No internal buffering; upstream must honour the same stall_in.
- Immediate formats by opcode[6:0]:
  - I: LOAD 0000011, OP-IMM 0010011, JALR 1100111 -> sext(instr[31:20]).
  - S: STORE 0100011 -> sext({[31:25],[11:7]}).
  - B: BRANCH 1100011 -> sext({[31],[7],[30:25],[11:8],0}).
  - U: LUI 0110111, AUIPC 0010111 -> {[31:12],12'b0}.
  - J: JAL 1101111 -> sext({[31],[19:12],[20],[30:21],0}).
  - OP 0110011 -> imm_value_out=0.
- funct3 to alu_op mapping (OP / OP-IMM): 000 ADD_SUB, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL_SRA, 110 OR, 111 AND.
- alu_sub_sra_out:
  - OP: instr[30] for funct3 000 and 101, else 0.
  - OP-IMM: instr[30] only for funct3 101, else 0.
  - All other classes: 0.
- Per-class decode:
  - OP: src REG/REG.
  - OP-IMM: src REG/IMM.
  - LUI: ZERO/IMM, ADD.
  - AUIPC: PC/IMM, ADD.
  - JAL, JALR: PC/FOUR, ADD, jump_out=1. JALR target is computed outside this block.
  - BRANCH: PC/IMM, ADD, branch_out=1, rd_write_out=0.
  - LOAD: REG/IMM, ADD, mem_read_out=1.
  - STORE: REG/IMM, ADD, mem_write_out=1, rd_write_out=0.
- rd_write_out=1 for OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD, only when rd != 0.
- illegal_out=1 for any of:
  - unknown opcode, or instr[1:0] != 11;
  - OP with funct7 not in {0000000, 0100000}, or funct7 0100000 with funct3 not in {000, 101};
  - OP-IMM shift whose funct7 is not 0000000 (SLLI/SRLI) or not in {0000000, 0100000} (SRAI);
  - JALR with funct3 != 000;
  - BRANCH with funct3 010 or 011;
  - LOAD with funct3 011, 110 or 111;
  - STORE with funct3 >= 011.
- When illegal_out=1: rd_write_out, class flags, mem flags all 0; valid_out follows valid_in so the trap is visible downstream.
- Reset asserted mid-stall or mid-flush: outputs go to reset values immediately; the held instruction is lost.

Test Plan:
- Reset: reset_n=0 asynchronously between edges -> valid_out=0, pc_out=0, alu_src1_out=alu_src2_out=00 immediately; outputs remain at reset values until the first edge after reset_n=1.
- instr=0x40B50533 (sub a0,a0,a1), valid_in=1 -> next cycle: alu_op_out=000, sub_sra=1, src REG/REG, rd_out=10, rd_write_out=1.
- instr=0xFFF00093 (addi x1,x0,-1), then 0x4020D093 (srai x1,x1,2) -> imm_value_out=0xFFFFFFFF and sub_sra=0; then alu_op=101, sub_sra=1, imm_value_out=0x402.
- instr=0x0080006F (jal x0,8) at pc 0x100 -> src PC/FOUR, jump_out=1, imm_value_out=8, rd_write_out=0 (rd=0).
- Load lui x5,0x12345 (0x123452B7); assert stall_in=1 for 3 cycles while changing instr_in -> outputs frozen with imm_value_out=0x12345000. Then assert flush_in and stall_in together -> valid_out=0 next edge.
- instr=0x0000007F, then 0x02B50533 (mul, funct7=0000001) -> illegal_out=1, valid_out=1, rd_write_out=0 in both cases.
